// File: rtl/alu_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundles the three handshake groups around alu_issue_ctrl:
//   id_*   : decoded instruction from the IDU (valid/ready)
//   ALU_*  : operand/start to the ALU and result/flags back (dat_ready/ALU_ready)
//   wb_*   : writeback/branch packet to the consumer (valid/ready), plus
//            br_taken/br_target/ex_err
// Modports:
//   slave  : view of alu_issue_ctrl
//   master : view of the surrounding environment (IDU, ALU, consumer)
// Parameters:
//   XLEN   : datapath width
// ----------------------------------------------------------------------------
interface alu_issue_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    // IDU side
    logic            id_valid;
    logic            id_ready;
    logic [4:0]      id_instr_code;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_pc;

    // ALU side
    logic [XLEN-1:0] ALU_dat1;
    logic [XLEN-1:0] ALU_dat2;
    logic [4:0]      Instruction_to_ALU;
    logic            ALU_optype;
    logic            dat_ready;
    logic [XLEN-1:0] ALU_out;
    logic            ALU_con_met;
    logic            ALU_overflow;
    logic            ALU_zero;
    logic            ALU_ready;

    // Writeback / branch side
    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd;
    logic            wb_we;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            ex_err;

    modport slave (
        input  id_valid, id_instr_code, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
               id_rd, id_pc,
        output id_ready,
        output ALU_dat1, ALU_dat2, Instruction_to_ALU, ALU_optype, dat_ready,
        input  ALU_out, ALU_con_met, ALU_overflow, ALU_zero, ALU_ready,
        output wb_valid, wb_data, wb_rd, wb_we, br_taken, br_target, ex_err,
        input  wb_ready
    );

    modport master (
        output id_valid, id_instr_code, id_rs1_val, id_rs2_val, id_imm, id_use_imm,
               id_rd, id_pc,
        input  id_ready,
        input  ALU_dat1, ALU_dat2, Instruction_to_ALU, ALU_optype, dat_ready,
        output ALU_out, ALU_con_met, ALU_overflow, ALU_zero, ALU_ready,
        input  wb_valid, wb_data, wb_rd, wb_we, br_taken, br_target, ex_err,
        output wb_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// Execute-stage sequencer between the IDU and the ALU. Takes one decoded
// instruction, presents the ALU operands for one setup cycle, raises
// dat_ready until the ALU answers (or a timeout expires), then holds a
// writeback/branch packet until the consumer accepts it.
//
// Ports:
//   soc_clk : clock
//   reset   : synchronous, active-high reset
//   io_bus  : alu_issue_ctrl_if.slave (id_*, ALU_*, wb_*/br_*/ex_err groups)
// Parameters:
//   XLEN           : datapath width
//   TIMEOUT_CYCLES : RUN cycles without ALU_ready before ex_err is flagged
// Configuration macro:
//   ALU_OVERFLOW_TRAP_EN : when defined, ALU_overflow on codes 6/7 turns the
//                          packet into an error (ex_err = 1, wb_we = 0);
//                          otherwise overflow is ignored (wrap semantics).
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic            soc_clk,
    input  logic            reset,
    alu_issue_ctrl_if.slave io_bus
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [4:0]  CodeInvalid = 5'd16;
    localparam logic [4:0]  CodeLastBr  = 5'd5;

    typedef enum logic [1:0] {StIdle, StSetup, StRun, StResult} state_e;

    state_e          r_state;
    state_e          w_state_nxt;

    // Latched instruction
    logic [4:0]      r_code;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_imm;
    logic            r_use_imm;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_pc;

    // Registered packet
    logic [XLEN-1:0] r_wb_data;
    logic            r_wb_we;
    logic            r_br_taken;
    logic [XLEN-1:0] r_br_target;
    logic            r_ex_err;

    logic [CntW-1:0] r_cnt;

    logic            w_is_branch;
    logic            w_is_slt;
    logic            w_timeout;
    logic [XLEN-1:0] w_cap_data;
    logic            w_cap_we;
    logic            w_cap_br;
    logic            w_cap_err;
    logic            w_unused_flags;

    assign w_is_branch = (r_code <= CodeLastBr);
    assign w_is_slt    = (r_code == 5'd9) || (r_code == 5'd10);
    // Last RUN cycle of the budget: counter started at 0 on entry to RUN.
    assign w_timeout   = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (io_bus.id_valid) begin
                    // Code 16 never reaches the ALU.
                    w_state_nxt = (io_bus.id_instr_code == CodeInvalid) ? StResult : StSetup;
                end
            end
            StSetup: w_state_nxt = StRun;
            StRun: begin
                if (io_bus.ALU_ready || w_timeout) begin
                    w_state_nxt = StResult;
                end
            end
            StResult: begin
                if (io_bus.wb_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. Everything outside its active state reads as 0.
    // ------------------------------------------------------------------------
    always_comb begin
        io_bus.id_ready           = 1'b0;
        io_bus.ALU_dat1           = '0;
        io_bus.ALU_dat2           = '0;
        io_bus.Instruction_to_ALU = '0;
        io_bus.ALU_optype         = 1'b0;
        io_bus.dat_ready          = 1'b0;
        io_bus.wb_valid           = 1'b0;
        io_bus.wb_data            = '0;
        io_bus.wb_rd              = '0;
        io_bus.wb_we              = 1'b0;
        io_bus.br_taken           = 1'b0;
        io_bus.br_target          = '0;
        io_bus.ex_err             = 1'b0;
        case (r_state)
            StIdle: io_bus.id_ready = 1'b1;
            StSetup, StRun: begin
                // Operands are already stable in SETUP, one cycle before dat_ready rises.
                io_bus.ALU_dat1           = r_rs1;
                io_bus.ALU_dat2           = (!w_is_branch && r_use_imm) ? r_imm : r_rs2;
                io_bus.Instruction_to_ALU = r_code;
                io_bus.ALU_optype         = (r_code > CodeLastBr);
                io_bus.dat_ready          = (r_state == StRun);
            end
            StResult: begin
                io_bus.wb_valid  = 1'b1;
                io_bus.wb_data   = r_wb_data;
                io_bus.wb_rd     = r_rd;
                io_bus.wb_we     = r_wb_we;
                io_bus.br_taken  = r_br_taken;
                io_bus.br_target = r_br_target;
                io_bus.ex_err    = r_ex_err;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Packet formed from the ALU answer
    // ------------------------------------------------------------------------
    always_comb begin
        w_cap_data = io_bus.ALU_out;
        w_cap_we   = (r_rd != 5'd0);
        w_cap_br   = 1'b0;
        w_cap_err  = 1'b0;
        if (w_is_branch) begin
            w_cap_data = '0;
            w_cap_we   = 1'b0;
            w_cap_br   = io_bus.ALU_con_met;
        end else if (w_is_slt) begin
            w_cap_data = {{(XLEN-1){1'b0}}, io_bus.ALU_con_met};
        end
`ifdef ALU_OVERFLOW_TRAP_EN
        if (((r_code == 5'd6) || (r_code == 5'd7)) && io_bus.ALU_overflow) begin
            w_cap_err = 1'b1;
            w_cap_we  = 1'b0;
        end
`endif
    end

    // Zero flag is not needed; overflow only matters with the trap enabled.
    assign w_unused_flags = io_bus.ALU_zero ^ io_bus.ALU_overflow;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            r_code      <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_imm       <= '0;
            r_use_imm   <= 1'b0;
            r_rd        <= '0;
            r_pc        <= '0;
            r_wb_data   <= '0;
            r_wb_we     <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_ex_err    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (io_bus.id_valid) begin
                        r_code      <= io_bus.id_instr_code;
                        r_rs1       <= io_bus.id_rs1_val;
                        r_rs2       <= io_bus.id_rs2_val;
                        r_imm       <= io_bus.id_imm;
                        r_use_imm   <= io_bus.id_use_imm;
                        r_rd        <= io_bus.id_rd;
                        r_pc        <= io_bus.id_pc;
                        r_cnt       <= '0;
                        // Pre-clear the packet; code 16 goes out exactly like this.
                        r_wb_data   <= '0;
                        r_wb_we     <= 1'b0;
                        r_br_taken  <= 1'b0;
                        r_br_target <= '0;
                        r_ex_err    <= (io_bus.id_instr_code == CodeInvalid);
                    end
                end
                StRun: begin
                    // ALU_ready takes priority over a simultaneous timeout.
                    if (io_bus.ALU_ready) begin
                        r_wb_data   <= w_cap_data;
                        r_wb_we     <= w_cap_we;
                        r_br_taken  <= w_cap_br;
                        r_br_target <= w_is_branch ? (r_pc + r_imm) : '0;
                        r_ex_err    <= w_cap_err;
                    end else if (w_timeout) begin
                        r_wb_data   <= '0;
                        r_wb_we     <= 1'b0;
                        r_br_taken  <= 1'b0;
                        r_br_target <= '0;
                        r_ex_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StResult: begin
                    if (io_bus.wb_ready) begin
                        r_ex_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
